// File: rtl/sdhci_cmd_pkg.sv
// Shared types and defaults for the SD command scheduler: response types, FSM states, CMD12 constants.
// The NCC_GAP state exists only when CMD_SCHED_NCC_GAP_EN is defined.
package sdhci_cmd_pkg;

  typedef enum logic [1:0] {
    RSP_NONE     = 2'd0,
    RSP_R48      = 2'd1,
    RSP_R48_BUSY = 2'd2,
    RSP_R136     = 2'd3
  } resp_type_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_TX_LOW   = 3'd2,
    ST_TX_HIGH  = 3'd3,
    ST_RSP_WAIT = 3'd4,
`ifdef CMD_SCHED_NCC_GAP_EN
    ST_RSP_RECV = 3'd5,
    ST_NCC_GAP  = 3'd6
`else
    ST_RSP_RECV = 3'd5
`endif
  } cmd_sched_state_e;

  localparam logic [5:0]  CMD12_INDEX = 6'd12;
  localparam int          NCR_MAX     = 64;
  localparam int          NCC_MIN     = 8;
  localparam logic [31:0] AUTO12_ARG  = 32'h0000_0000;

endpackage

// File: rtl/cmd_scheduler_cnt.sv
// 7-bit cycle counter used for Ncr/Ncc timing; clears on state entry, otherwise counts while enabled.
module cmd_scheduler_cnt (
  input  logic       sd_freq_clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [6:0] cnt_o
);

  // Cycle counter register
  always_ff @(posedge sd_freq_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= 7'd0;
    end else if (clr_i) begin
      cnt_o <= 7'd0;
    end else if (en_i) begin
      cnt_o <= cnt_o + 7'd1;
    end else begin
      cnt_o <= cnt_o;
    end
  end

endmodule

// File: rtl/cmd_scheduler.sv
// SD CMD-line scheduler: arbitrates host commands against auto-CMD12, launches the transmitter and
// supervises the Ncr response window. Optional post-response idle gap under CMD_SCHED_NCC_GAP_EN.
module cmd_scheduler
  import sdhci_cmd_pkg::*;
#(
  parameter int          NcrMax    = NCR_MAX,
`ifdef CMD_SCHED_NCC_GAP_EN
  parameter int          NccMin    = NCC_MIN,
`endif
  parameter logic [31:0] Auto12Arg = AUTO12_ARG
) (
  input  logic        sd_freq_clk_i,
  input  logic        rst_ni,
  input  logic        host_req_i,
  input  logic [5:0]  host_cmd_nr_i,
  input  logic [31:0] host_arg_i,
  input  resp_type_e  host_rsp_type_i,
  input  logic        auto12_req_i,
  output logic        start_tx_o,
  output logic [5:0]  cmd_nr_o,
  output logic [31:0] cmd_argument_o,
  input  logic        tx_done_i,
  output logic        rsp_listen_o,
  output logic        rsp_long_o,
  input  logic        rsp_start_i,
  input  logic        rsp_done_i,
  output logic        cmd_inhibit_o,
  output logic        cmd_complete_o,
  output logic        cmd_timeout_o,
  output logic        active_src_o
);

  // The timeout pulse is registered, so the decision is taken one count early to land NcrMax
  // cycles after tx_done_i rises.
  localparam logic [6:0] NCR_LAST = 7'(NcrMax - 2);
`ifdef CMD_SCHED_NCC_GAP_EN
  localparam logic [6:0]       NCC_LAST  = 7'(NccMin - 1);
  localparam cmd_sched_state_e END_STATE = ST_NCC_GAP;
`else
  localparam cmd_sched_state_e END_STATE = ST_IDLE;
`endif

  cmd_sched_state_e state_r, state_s;
  logic        host_pend_r, host_pend_s, auto12_pend_r, auto12_pend_s, host_cap_s;
  logic [5:0]  host_nr_r;
  logic [31:0] host_arg_r;
  resp_type_e  host_type_r, cur_type_r;
  logic        issue_s, cpl_s, tmo_s, cnt_clr_s, cnt_en_s;
  logic [6:0]  cnt_s;

  assign cnt_clr_s = (state_s != state_r);
`ifdef CMD_SCHED_NCC_GAP_EN
  assign cnt_en_s  = (state_r == ST_RSP_WAIT) || (state_r == ST_NCC_GAP);
`else
  assign cnt_en_s  = (state_r == ST_RSP_WAIT);
`endif

  cmd_scheduler_cnt u_cnt (
    .sd_freq_clk_i (sd_freq_clk_i),
    .rst_ni        (rst_ni),
    .clr_i         (cnt_clr_s),
    .en_i          (cnt_en_s),
    .cnt_o         (cnt_s)
  );

  // Next-state and per-cycle event decode
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    cpl_s   = 1'b0;
    tmo_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((host_pend_r || auto12_pend_r) && tx_done_i) begin
          state_s = ST_ISSUE;
          issue_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_TX_LOW;
      ST_TX_LOW: begin
        if (!tx_done_i) state_s = ST_TX_HIGH;
        else            state_s = ST_TX_LOW;
      end
      ST_TX_HIGH: begin
        if (!tx_done_i) begin
          state_s = ST_TX_HIGH;
        end else if (cur_type_r == RSP_NONE) begin
          state_s = END_STATE;
          cpl_s   = 1'b1;
        end else begin
          state_s = ST_RSP_WAIT;
        end
      end
      ST_RSP_WAIT: begin
        if (rsp_start_i && rsp_done_i) begin
          state_s = END_STATE;
          cpl_s   = 1'b1;
        end else if (rsp_start_i) begin
          state_s = ST_RSP_RECV;
        end else if (cnt_s == NCR_LAST) begin
          state_s = END_STATE;
          tmo_s   = 1'b1;
        end else begin
          state_s = ST_RSP_WAIT;
        end
      end
      ST_RSP_RECV: begin
        if (rsp_done_i) begin
          state_s = END_STATE;
          cpl_s   = 1'b1;
        end else begin
          state_s = ST_RSP_RECV;
        end
      end
`ifdef CMD_SCHED_NCC_GAP_EN
      ST_NCC_GAP: begin
        if (cnt_s == NCC_LAST) state_s = ST_IDLE;
        else                   state_s = ST_NCC_GAP;
      end
`endif
      default: state_s = ST_IDLE;
    endcase
  end

  // Pending-request flags; an issue clears the flag it serves, CMD12 has priority
  always_comb begin
    host_cap_s = host_req_i && !cmd_inhibit_o;
    if (issue_s && auto12_pend_r) auto12_pend_s = 1'b0;
    else if (auto12_req_i)        auto12_pend_s = 1'b1;
    else                          auto12_pend_s = auto12_pend_r;
    if (issue_s && !auto12_pend_r) host_pend_s = 1'b0;
    else if (host_cap_s)           host_pend_s = 1'b1;
    else                           host_pend_s = host_pend_r;
  end

  // State, request capture and command latch
  always_ff @(posedge sd_freq_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r        <= ST_IDLE;
      host_pend_r    <= 1'b0;
      auto12_pend_r  <= 1'b0;
      host_nr_r      <= 6'd0;
      host_arg_r     <= 32'd0;
      host_type_r    <= RSP_NONE;
      cur_type_r     <= RSP_NONE;
      cmd_nr_o       <= 6'd0;
      cmd_argument_o <= 32'd0;
      active_src_o   <= 1'b0;
      rsp_long_o     <= 1'b0;
    end else begin
      state_r       <= state_s;
      host_pend_r   <= host_pend_s;
      auto12_pend_r <= auto12_pend_s;
      if (host_cap_s) begin
        host_nr_r   <= host_cmd_nr_i;
        host_arg_r  <= host_arg_i;
        host_type_r <= host_rsp_type_i;
      end
      if (issue_s && auto12_pend_r) begin
        cmd_nr_o       <= CMD12_INDEX;
        cmd_argument_o <= Auto12Arg;
        cur_type_r     <= RSP_R48_BUSY;
        active_src_o   <= 1'b1;
        rsp_long_o     <= 1'b0;
      end else if (issue_s) begin
        cmd_nr_o       <= host_nr_r;
        cmd_argument_o <= host_arg_r;
        cur_type_r     <= host_type_r;
        active_src_o   <= 1'b0;
        rsp_long_o     <= (host_type_r == RSP_R136);
      end
    end
  end

  // Registered strobes and status outputs
  always_ff @(posedge sd_freq_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_tx_o     <= 1'b0;
      rsp_listen_o   <= 1'b0;
      cmd_complete_o <= 1'b0;
      cmd_timeout_o  <= 1'b0;
      cmd_inhibit_o  <= 1'b0;
    end else begin
      start_tx_o     <= issue_s;
      rsp_listen_o   <= (state_s == ST_RSP_WAIT) || (state_s == ST_RSP_RECV);
      cmd_complete_o <= cpl_s;
      cmd_timeout_o  <= tmo_s;
      cmd_inhibit_o  <= (state_s != ST_IDLE) || host_pend_s;
    end
  end

endmodule

// File: tb/tb_cmd_scheduler.sv
// Randomized bench for cmd_scheduler: a queue of expected commands plus a transmitter/responder model
// predicts every launch, completion and timeout cycle from the command timing rules.
module tb_cmd_scheduler;
  import sdhci_cmd_pkg::*;

`ifdef CMD_SCHED_NCC_GAP_EN
  localparam int GAP = 8;
`else
  localparam int GAP = 0;
`endif
  localparam int TX_BITS = 48;
  localparam int NCR     = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_req = 1'b0;
  logic [5:0]  host_nr = 6'd0;
  logic [31:0] host_arg = 32'd0;
  resp_type_e  host_type = RSP_NONE;
  logic        auto12_req = 1'b0;
  logic        tx_done = 1'b1;
  logic        rsp_start = 1'b0;
  logic        rsp_done = 1'b0;
  logic        start_tx, rsp_listen, rsp_long, inhibit, cpl, tmo, src;
  logic [5:0]  cmd_nr;
  logic [31:0] cmd_arg;

  typedef struct {
    int          req;
    logic        src;
    logic [5:0]  nr;
    logic [31:0] arg;
    resp_type_e  t;
    int          d;
    int          len;
  } plan_t;

  plan_t exp_q[$];
  plan_t cur;
  bit    busy = 1'b0;
  bit    is_to, saw_listen;
  int    s_cyc, t_cyc, e_cyc;
  int    last_end = -1000;
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;

  cmd_scheduler dut (
    .sd_freq_clk_i   (clk),
    .rst_ni          (rst_n),
    .host_req_i      (host_req),
    .host_cmd_nr_i   (host_nr),
    .host_arg_i      (host_arg),
    .host_rsp_type_i (host_type),
    .auto12_req_i    (auto12_req),
    .start_tx_o      (start_tx),
    .cmd_nr_o        (cmd_nr),
    .cmd_argument_o  (cmd_arg),
    .tx_done_i       (tx_done),
    .rsp_listen_o    (rsp_listen),
    .rsp_long_o      (rsp_long),
    .rsp_start_i     (rsp_start),
    .rsp_done_i      (rsp_done),
    .cmd_inhibit_o   (inhibit),
    .cmd_complete_o  (cpl),
    .cmd_timeout_o   (tmo),
    .active_src_o    (src)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit host_queued();
    foreach (exp_q[i]) if (!exp_q[i].src && exp_q[i].req < cyc) return 1'b1;
    return 1'b0;
  endfunction

  // Transmitter + responder model and output checker, all evaluated on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_done = 1'b1; rsp_start = 1'b0; rsp_done = 1'b0;
      busy = 1'b0; exp_q.delete(); last_end = -1000;
    end else begin
      rsp_start = 1'b0;
      rsp_done  = 1'b0;
      if (start_tx) begin
        if (busy || exp_q.size() == 0) begin
          check_val("spurious_start", 64'(start_tx), 64'd0);
        end else begin
          cur = exp_q.pop_front();
          busy = 1'b1; s_cyc = cyc; t_cyc = cyc + 2 + TX_BITS; saw_listen = 1'b0;
          is_to = (cur.t != RSP_NONE) && (cur.d == 0);
          if (cur.t == RSP_NONE) e_cyc = t_cyc + 1;
          else if (is_to)        e_cyc = t_cyc + NCR;
          else                   e_cyc = t_cyc + cur.d + cur.len + 1;
          check_val("start_cycle", 64'(cyc),
                    64'((cur.req + 2 > last_end + 1 + GAP) ? cur.req + 2 : last_end + 1 + GAP));
          check_val("cmd_nr", 64'(cmd_nr), 64'(cur.nr));
          check_val("cmd_arg", 64'(cmd_arg), 64'(cur.arg));
          check_val("active_src", 64'(src), 64'(cur.src));
          check_val("rsp_long", 64'(rsp_long), 64'(cur.t == RSP_R136));
          check_val("inhibit_start", 64'(inhibit), 64'd1);
        end
      end
      if (busy) begin
        if (cyc == s_cyc + 2) tx_done = 1'b0;
        if (cyc == t_cyc)     tx_done = 1'b1;
        if (cur.t != RSP_NONE && cur.d != 0) begin
          if (cyc == t_cyc + cur.d)           rsp_start = 1'b1;
          if (cyc == t_cyc + cur.d + cur.len) rsp_done  = 1'b1;
        end
        if (rsp_listen) saw_listen = 1'b1;
        if (cur.t != RSP_NONE && cyc == t_cyc + 1) check_val("listen_open", 64'(rsp_listen), 64'd1);
      end
      if (cpl || tmo || (busy && cyc == e_cyc)) begin
        check_val("complete", 64'(cpl), 64'(busy && cyc == e_cyc && !is_to));
        check_val("timeout", 64'(tmo), 64'(busy && cyc == e_cyc && is_to));
        if (busy && cyc == e_cyc) begin
          check_val("inhibit_end", 64'(inhibit), 64'((GAP > 0) || host_queued()));
          if (cur.t == RSP_NONE) check_val("listen_none", 64'(saw_listen), 64'd0);
          busy = 1'b0;
          last_end = cyc;
        end
      end
    end
  end

  task automatic push(input int req, input logic s, input logic [5:0] nr, input logic [31:0] arg,
                      input resp_type_e t, input int d, input int len);
    plan_t p;
    p.req = req; p.src = s; p.nr = nr; p.arg = arg; p.t = t; p.d = d; p.len = len;
    exp_q.push_back(p);
  endtask

  task automatic send_host(input logic [5:0] nr, input logic [31:0] arg, input resp_type_e t,
                           input int d, input int len, input bit with_a12, input int a_d, input int a_len);
    @(negedge clk);
    host_req = 1'b1; host_nr = nr; host_arg = arg; host_type = t; auto12_req = with_a12;
    if (with_a12) push(cyc, 1'b1, 6'd12, 32'd0, RSP_R48_BUSY, a_d, a_len);
    push(cyc, 1'b0, nr, arg, t, d, len);
    @(negedge clk);
    host_req = 1'b0; auto12_req = 1'b0;
    host_nr = 6'($urandom); host_arg = $urandom;
  endtask

  task automatic send_a12(input bit dbl, input int d, input int len);
    @(negedge clk);
    auto12_req = 1'b1;
    push(cyc, 1'b1, 6'd12, 32'd0, RSP_R48_BUSY, d, len);
    @(negedge clk);
    auto12_req = dbl;
    @(negedge clk);
    auto12_req = 1'b0;
  endtask

  task automatic wait_until_cyc(input bit need_busy, input int target);
    int n = 0;
    while (!((busy || !need_busy) && cyc >= target) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val("reach_point", 64'(n < 400), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0 || inhibit) && n < budget);
    check_val("drained", 64'(!(busy || exp_q.size() != 0 || inhibit)), 64'd1);
  endtask

  task automatic check_zero(input string ph);
    check_val({ph, "_start_tx"}, 64'(start_tx), 64'd0);
    check_val({ph, "_cmd_nr"}, 64'(cmd_nr), 64'd0);
    check_val({ph, "_cmd_arg"}, 64'(cmd_arg), 64'd0);
    check_val({ph, "_listen"}, 64'(rsp_listen), 64'd0);
    check_val({ph, "_long"}, 64'(rsp_long), 64'd0);
    check_val({ph, "_inhibit"}, 64'(inhibit), 64'd0);
    check_val({ph, "_complete"}, 64'(cpl), 64'd0);
    check_val({ph, "_timeout"}, 64'(tmo), 64'd0);
    check_val({ph, "_src"}, 64'(src), 64'd0);
  endtask

  task automatic rand_rsp(output resp_type_e t, output int d, output int len);
    t = resp_type_e'(2'($urandom_range(0, 3)));
    case ($urandom_range(0, 5))
      0:       d = 0;
      1:       d = 63;
      default: d = $urandom_range(1, 62);
    endcase
    len = (t == RSP_R136) ? $urandom_range(0, 135) : $urandom_range(0, 47);
  endtask

  initial begin
    resp_type_e t, ta;
    int d, len, ad, alen;
    repeat (3) @(negedge clk);
    check_zero("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_host(6'd8, 32'h0000_01AA, RSP_R48, 10, 48, 1'b0, 0, 0);
    wait_idle(400);
    send_host(6'd0, 32'd0, RSP_NONE, 0, 0, 1'b0, 0, 0);
    wait_idle(400);
    send_host(6'd17, 32'h0000_0200, RSP_R48, 0, 0, 1'b0, 0, 0);
    wait_idle(400);
    send_host(6'd55, 32'hDEAD_BEEF, RSP_R48, 5, 20, 1'b1, 7, 10);
    wait_idle(600);

    // Host command with an ignored second request and a CMD12 arriving mid-response
    send_host(6'd18, 32'h0000_1000, RSP_R48, 10, 30, 1'b0, 0, 0);
    wait_until_cyc(1'b1, s_cyc + 5);
    check_val("inhibit_busy", 64'(inhibit), 64'd1);
    host_req = 1'b1; host_nr = 6'd33; host_type = RSP_NONE;
    @(negedge clk);
    host_req = 1'b0;
    wait_until_cyc(1'b1, t_cyc + 12);
    auto12_req = 1'b1;
    push(cyc, 1'b1, 6'd12, 32'd0, RSP_R48_BUSY, 4, 6);
    @(negedge clk);
    auto12_req = 1'b0;
    wait_idle(600);

    // Asynchronous reset while the transmitter is busy
    send_host(6'd9, 32'h1234_0000, RSP_R136, 8, 100, 1'b0, 0, 0);
    wait_until_cyc(1'b1, s_cyc + 20);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_host(6'd8, 32'h0000_01AA, RSP_R48, 63, 47, 1'b0, 0, 0);
    wait_idle(400);

    for (int i = 0; i < 30; i++) begin
      rand_rsp(t, d, len);
      rand_rsp(ta, ad, alen);
      case ($urandom_range(0, 3))
        0: send_host(6'($urandom), $urandom, t, d, len, 1'b0, 0, 0);
        1: send_host(6'($urandom), $urandom, t, d, len, 1'b1, ad, alen);
        2: send_a12(1'($urandom), ad, alen);
        default: begin
          if (d == 0) d = 5;
          if (len < 4) len = 4;
          send_host(6'($urandom), $urandom, t, d, len, 1'b0, 0, 0);
          wait_until_cyc(1'b1, s_cyc + 5);
          host_req = 1'b1; host_nr = 6'($urandom);
          @(negedge clk);
          host_req = 1'b0;
          if (t != RSP_NONE) begin
            wait_until_cyc(1'b1, t_cyc + d + 2);
            auto12_req = 1'b1;
            push(cyc, 1'b1, 6'd12, 32'd0, RSP_R48_BUSY, ad, alen);
            @(negedge clk);
            auto12_req = 1'b0;
          end
        end
      endcase
      wait_idle(800);
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
